// File: rtl/sensor_scan_sequencer.sv
`timescale 1ns/1ps
// Frame scheduler for the linear optical sensor: SI/ADC start pulse, pixel walk,
// flush clocks and a programmable integration gap, single-shot or free-running.
module sensor_scan_sequencer #(
  parameter int N_PIXELS   = 128,
  parameter int EXTRA_CLKS = 1,
  parameter int GAP_W      = 16
) (
  input  logic             sensor_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             continuous,
  input  logic             trigger,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             clear_flags,
  output logic             si,
  output logic             sample_control,
  output logic [6:0]       pixel_idx,
  output logic             pixel_valid,
  output logic             frame_done,
  output logic [15:0]      frame_count,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [2:0] {S_IDLE, S_SI, S_READ, S_FLUSH, S_GAP} state_t;

  localparam logic [6:0] PIX_LAST   = 7'(N_PIXELS - 1);
  localparam logic [7:0] FLUSH_LAST = 8'((EXTRA_CLKS > 0) ? EXTRA_CLKS - 1 : 0);
  localparam logic       NO_FLUSH   = (EXTRA_CLKS == 0);

  state_t           state, state_n;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       flush_cnt;

  logic read_last, flush_last, frame_end, gap_last, frame_exit, launch;

  assign read_last  = (state == S_READ) && (pixel_idx == PIX_LAST);
  assign flush_last = (state == S_FLUSH) && (flush_cnt == FLUSH_LAST);
  assign frame_end  = (read_last && NO_FLUSH) || flush_last;
  assign gap_last   = (state == S_GAP) && (gap_cnt == gap_q);
  // A frame with no gap leaves straight from its final read/flush cycle.
  assign frame_exit = (frame_end && (gap_q == '0)) || gap_last;
  assign launch     = ((state == S_IDLE) && enable && (continuous || trigger)) ||
                      (frame_exit && enable && continuous);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (launch) state_n = S_SI;
      S_SI:    state_n = S_READ;
      S_READ:  if (read_last) state_n = NO_FLUSH ? S_GAP : S_FLUSH;
      S_FLUSH: if (flush_last) state_n = S_GAP;
      S_GAP:   state_n = S_GAP;
      default: state_n = S_IDLE;
    endcase
    if (frame_exit) state_n = launch ? S_SI : S_IDLE;
  end

  always_ff @(posedge sensor_clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      si             <= 1'b0;
      sample_control <= 1'b0;
      pixel_idx      <= '0;
      pixel_valid    <= 1'b0;
      frame_done     <= 1'b0;
      frame_count    <= '0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
      gap_q          <= '0;
      gap_cnt        <= '0;
      flush_cnt      <= '0;
    end else begin
      state          <= state_n;
      busy           <= (state_n != S_IDLE);
      si             <= (state_n == S_SI);
      sample_control <= (state_n == S_SI);
      pixel_valid    <= (state_n == S_READ);
      frame_done     <= frame_end;
      if (frame_end) frame_count <= frame_count + 16'd1;

      // A fresh overrun wins over a simultaneous clear.
      if (trigger && (state != S_IDLE)) overrun <= 1'b1;
      else if (clear_flags)             overrun <= 1'b0;

      if (state == S_SI) gap_q <= gap_cycles;

      if (state == S_SI)                     pixel_idx <= '0;
      else if ((state == S_READ) && !read_last) pixel_idx <= pixel_idx + 7'd1;

      if (state == S_FLUSH) flush_cnt <= flush_cnt + 8'd1;
      else                  flush_cnt <= '0;

      if (frame_end)           gap_cnt <= GAP_W'(1);
      else if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_sensor_scan_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for sensor_scan_sequencer: directed frames push expected si/pixel/frame_done
// events into queues; a negedge monitor pops and compares them as the DUT emits them.
module tb_sensor_scan_sequencer;
  localparam int NP = 128;

  logic        sensor_clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        continuous = 1'b0;
  logic        trigger = 1'b0;
  logic [15:0] gap_cycles = 16'd10;
  logic        clear_flags = 1'b0;
  logic        si, sample_control, pixel_valid, frame_done, busy, overrun;
  logic [6:0]  pixel_idx;
  logic [15:0] frame_count;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct { int cyc; logic [15:0] cnt; } done_t;
  int    si_q[$];
  int    pix_q[$];
  done_t done_q[$];

  sensor_scan_sequencer dut (
    .sensor_clk(sensor_clk), .reset(reset), .enable(enable), .continuous(continuous),
    .trigger(trigger), .gap_cycles(gap_cycles), .clear_flags(clear_flags),
    .si(si), .sample_control(sample_control), .pixel_idx(pixel_idx),
    .pixel_valid(pixel_valid), .frame_done(frame_done), .frame_count(frame_count),
    .busy(busy), .overrun(overrun)
  );

  always #5 sensor_clk = ~sensor_clk;
  always @(posedge sensor_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event with empty scoreboard at cycle %0d", nm, cyc);
  endtask

  task automatic tick();
    @(negedge sensor_clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_frame(input int t_si, input logic [15:0] cnt);
    done_t d;
    si_q.push_back(t_si);
    for (int i = 0; i < NP; i++) pix_q.push_back(i);
    d.cyc = t_si + NP + 2;
    d.cnt = cnt;
    done_q.push_back(d);
  endtask

  // Monitor
  always @(negedge sensor_clk) begin
    if (!reset) begin
      if (si || sample_control) begin
        chk("sc_with_si", {31'd0, sample_control}, {31'd0, si});
        if (si_q.size() == 0) unexpected("si");
        else chk("si_cycle", cyc, si_q.pop_front());
      end
      if (pixel_valid) begin
        if (pix_q.size() == 0) unexpected("pixel_valid");
        else chk("pixel_idx", {25'd0, pixel_idx}, pix_q.pop_front());
      end
      if (frame_done) begin
        if (done_q.size() == 0) unexpected("frame_done");
        else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_count", {16'd0, frame_count}, {16'd0, d.cnt});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) tick();
    chk("reset_state", {10'd0, si, sample_control, pixel_valid, frame_done, busy, overrun, frame_count}, 32'd0);
    reset = 1'b0;
    tick();

    // Reset mid-READ at pixel 40
    t = cyc;
    si_q.push_back(t + 1);
    for (int i = 0; i <= 40; i++) pix_q.push_back(i);
    trigger = 1'b1; tick(); trigger = 1'b0;
    wait_to(t + 42);
    chk("pix40_before_reset", {24'd0, pixel_valid, pixel_idx}, {24'd0, 1'b1, 7'd40});
    reset = 1'b1;
    wait_to(t + 43);
    chk("reset_mid_frame", {10'd0, si, sample_control, pixel_valid, frame_done, busy, overrun, frame_count}, 32'd0);
    reset = 1'b0;
    tick();

    // Single shot, gap 10
    t = cyc;
    expect_frame(t + 1, 16'd1);
    trigger = 1'b1; tick(); trigger = 1'b0;
    wait_to(t + 130);
    chk("flush_no_pixel", {31'd0, pixel_valid}, 32'd0);
    wait_to(t + 140);
    chk("busy_in_gap", {31'd0, busy}, 32'd1);
    wait_to(t + 141);
    chk("busy_after_gap", {31'd0, busy}, 32'd0);
    chk("count_single", {16'd0, frame_count}, 32'd1);

    // Continuous, gap 10, five frames from a cleared counter
    reset = 1'b1; tick(); reset = 1'b0; tick();
    t = cyc;
    for (int k = 0; k < 5; k++) expect_frame(t + 1 + 140 * k, 16'(k + 1));
    continuous = 1'b1;
    wait_to(t + 571);
    continuous = 1'b0;
    wait_to(t + 700);
    chk("busy_last_gap", {31'd0, busy}, 32'd1);
    wait_to(t + 701);
    chk("idle_after_cont", {31'd0, busy}, 32'd0);
    chk("count_five", {16'd0, frame_count}, 32'd5);

    // Continuous, gap 0: back-to-back frames
    gap_cycles = 16'd0;
    tick();
    t = cyc;
    for (int k = 0; k < 3; k++) expect_frame(t + 1 + 130 * k, 16'(6 + k));
    continuous = 1'b1;
    wait_to(t + 129);
    chk("pv_last_pixel", {31'd0, pixel_valid}, 32'd1);
    wait_to(t + 130);
    chk("pv_flush", {31'd0, pixel_valid}, 32'd0);
    wait_to(t + 131);
    chk("pv_si", {31'd0, pixel_valid}, 32'd0);
    wait_to(t + 132);
    chk("pv_next_frame", {31'd0, pixel_valid}, 32'd1);
    wait_to(t + 271);
    continuous = 1'b0;
    wait_to(t + 390);
    chk("busy_b2b_flush", {31'd0, busy}, 32'd1);
    wait_to(t + 391);
    chk("idle_b2b", {31'd0, busy}, 32'd0);

    // Overrun handling
    t = cyc;
    expect_frame(t + 1, 16'd9);
    trigger = 1'b1; tick(); trigger = 1'b0;
    chk("no_overrun_on_start", {31'd0, overrun}, 32'd0);
    wait_to(t + 66);
    chk("pix64", {25'd0, pixel_idx}, 32'd64);
    trigger = 1'b1; tick(); trigger = 1'b0;
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    wait_to(t + 70);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("overrun_cleared", {31'd0, overrun}, 32'd0);
    wait_to(t + 80);
    clear_flags = 1'b1; trigger = 1'b1; tick(); clear_flags = 1'b0; trigger = 1'b0;
    chk("overrun_set_wins", {31'd0, overrun}, 32'd1);
    wait_to(t + 131);
    chk("idle_after_overrun_frame", {31'd0, busy}, 32'd0);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("overrun_idle_clear", {31'd0, overrun}, 32'd0);
    enable = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (3) tick();
    chk("disabled_trigger_busy", {31'd0, busy}, 32'd0);
    chk("disabled_trigger_overrun", {31'd0, overrun}, 32'd0);
    enable = 1'b1;

    // enable dropped mid-frame with the counter at its wrap point
    tick();
    force dut.frame_count = 16'hFFFF;
    tick();
    release dut.frame_count;
    tick();
    chk("count_preset", {16'd0, frame_count}, 32'h0000FFFF);
    t = cyc;
    expect_frame(t + 1, 16'd0);
    continuous = 1'b1;
    wait_to(t + 12);
    chk("pix10", {25'd0, pixel_idx}, 32'd10);
    enable = 1'b0;
    wait_to(t + 131);
    chk("idle_after_disable", {31'd0, busy}, 32'd0);
    chk("count_wrapped", {16'd0, frame_count}, 32'd0);
    repeat (10) tick();
    continuous = 1'b0;

    chk("si_q_drained", si_q.size(), 32'd0);
    chk("pix_q_drained", pix_q.size(), 32'd0);
    chk("done_q_drained", done_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
